led_pwm_fader: RTL and testbench



---
 rtl/led_pwm_fader.sv | 154 +++++++++++++++
 tb/tb_led_pwm_fader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// Breathing-fade PWM driver for the blinker LED: linear duty ramp, fixed-rate PWM output.
// Optional perceptual curve on the compare value: define LED_PWM_FADER_GAMMA_EN.
//
// state  | meaning
// S_OFF  | duty held at 0, waiting for led_q
// S_UP   | ramping duty up one step per FADE_PERIODS PWM periods
// S_ON   | duty held at 255, waiting for led_q to drop
// S_DOWN | ramping duty down one step per FADE_PERIODS PWM periods
module led_pwm_fader #(
   parameter int CLK_FREQ_KHz = 50000,
   parameter int PWM_FREQ_Hz  = 1000,
   parameter int FADE_PERIODS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       led_in,
   output logic       led_pwm,
   output logic [7:0] duty,
   output logic       busy
);

   localparam int PRESCALE = (CLK_FREQ_KHz * 1000) / (PWM_FREQ_Hz * 256);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] STEP_LAST  = SW'(FADE_PERIODS - 1);

   generate
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("led_pwm_fader: PRESCALE must be >= 1");
      end
      if (FADE_PERIODS < 1) begin : g_bad_fade
         $error("led_pwm_fader: FADE_PERIODS must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

   state_t        state_q;
   logic          led_q;
   logic [PW-1:0] presc_cnt_q;
   logic [7:0]    pwm_cnt_q;
   logic [SW-1:0] step_cnt_q;
   logic [7:0]    duty_q;
   logic          busy_q;
   logic          led_pwm_q;
   logic          tick;
   logic          period_end;
   logic          step;
   logic [7:0]    cmp;

   assign tick       = (presc_cnt_q == PRESC_LAST);
   assign period_end = tick && (pwm_cnt_q == 8'hff);
   assign step       = period_end && (step_cnt_q == STEP_LAST);

`ifdef LED_PWM_FADER_GAMMA_EN
   logic [7:0] gamma_unused;
   assign {cmp, gamma_unused} = {8'd0, duty_q} * {8'd0, duty_q} + 16'd255;
`else
   assign cmp = duty_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q       <= 1'b0;
         presc_cnt_q <= '0;
         pwm_cnt_q   <= '0;
      end else begin
         led_q <= led_in;
         if (tick) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= pwm_cnt_q + 8'd1;
         end else begin
            presc_cnt_q <= presc_cnt_q + PW'(1);
         end
      end
   end

   // Any state change restarts the step counter so the next step waits a full fade interval.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_OFF;
         duty_q     <= '0;
         busy_q     <= 1'b0;
         step_cnt_q <= '0;
         led_pwm_q  <= 1'b0;
      end else begin
         led_pwm_q <= (pwm_cnt_q < cmp);
         if (period_end) begin
            step_cnt_q <= step ? '0 : step_cnt_q + SW'(1);
         end
         case (state_q)
            S_OFF: begin
               if (led_q) begin
                  state_q    <= S_UP;
                  busy_q     <= 1'b1;
                  step_cnt_q <= '0;
               end
            end
            S_UP: begin
               if (!led_q) begin
                  state_q    <= S_DOWN;
                  step_cnt_q <= '0;
               end else if (duty_q == 8'hff) begin
                  state_q    <= S_ON;
                  busy_q     <= 1'b0;
                  step_cnt_q <= '0;
               end else if (step) begin
                  duty_q <= duty_q + 8'd1;
                  if (duty_q == 8'hfe) begin
                     state_q    <= S_ON;
                     busy_q     <= 1'b0;
                     step_cnt_q <= '0;
                  end
               end
            end
            S_ON: begin
               if (!led_q) begin
                  state_q    <= S_DOWN;
                  busy_q     <= 1'b1;
                  step_cnt_q <= '0;
               end
            end
            S_DOWN: begin
               if (led_q) begin
                  state_q    <= S_UP;
                  step_cnt_q <= '0;
               end else if (duty_q == 8'h00) begin
                  state_q    <= S_OFF;
                  busy_q     <= 1'b0;
                  step_cnt_q <= '0;
               end else if (step) begin
                  duty_q <= duty_q - 8'd1;
                  if (duty_q == 8'h01) begin
                     state_q    <= S_OFF;
                     busy_q     <= 1'b0;
                     step_cnt_q <= '0;
                  end
               end
            end
            default: begin
               state_q <= S_OFF;
               duty_q  <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign led_pwm = led_pwm_q;
   assign duty    = duty_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Scoreboard bench for led_pwm_fader: four instances (slow/fast prescale, FADE_PERIODS 1 and 4)
// run in parallel; stimulus queues expectations, per-instance monitors pop and compare.
module tb_led_pwm_fader;

   typedef enum int {K_DUTY, K_BUSY, K_PWM, K_PCNT, K_HIGH} kind_t;
   typedef struct { string name; kind_t kind; int exp; int len; } chk_t;
   typedef struct { int val; int cyc; } dexp_t;

`ifdef LED_PWM_FADER_GAMMA_EN
   localparam bit GAMMA = 1'b1;
`else
   localparam bit GAMMA = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_g;
   logic       rst_x  [4];
   logic       led_w  [4];
   logic       pwm_w  [4];
   logic [7:0] duty_w [4];
   logic       busy_w [4];
   logic [7:0] pcnt0;

   chk_t  sbq [4][$];
   dexp_t dq  [4][$];
   int n_cmp = 0;
   int n_err = 0;

   // u0: PRESCALE=3 (768 clk period); u1..u3: PRESCALE=1 (256 clk period)
   led_pwm_fader #(.CLK_FREQ_KHz(1), .PWM_FREQ_Hz(1), .FADE_PERIODS(1)) u0 (
      .clk(clk), .rst(rst_g | rst_x[0]), .led_in(led_w[0]),
      .led_pwm(pwm_w[0]), .duty(duty_w[0]), .busy(busy_w[0]));
   led_pwm_fader #(.CLK_FREQ_KHz(1), .PWM_FREQ_Hz(3), .FADE_PERIODS(1)) u1 (
      .clk(clk), .rst(rst_g | rst_x[1]), .led_in(led_w[1]),
      .led_pwm(pwm_w[1]), .duty(duty_w[1]), .busy(busy_w[1]));
   led_pwm_fader #(.CLK_FREQ_KHz(1), .PWM_FREQ_Hz(3), .FADE_PERIODS(1)) u2 (
      .clk(clk), .rst(rst_g | rst_x[2]), .led_in(led_w[2]),
      .led_pwm(pwm_w[2]), .duty(duty_w[2]), .busy(busy_w[2]));
   led_pwm_fader #(.CLK_FREQ_KHz(1), .PWM_FREQ_Hz(3), .FADE_PERIODS(4)) u3 (
      .clk(clk), .rst(rst_g | rst_x[3]), .led_in(led_w[3]),
      .led_pwm(pwm_w[3]), .duty(duty_w[3]), .busy(busy_w[3]));

   assign pcnt0 = u0.pwm_cnt_q;

   // n counts edges after reset release; edge n is global cycle n+2.
   task automatic wait_n(input int n);
      while (cyc < n + 2) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic void chk(input int i, input string nm, input kind_t k, input int e,
                               input int len = 1);
      chk_t c;
      c.name = nm; c.kind = k; c.exp = e; c.len = len;
      sbq[i].push_back(c);
   endfunction

   function automatic void exp_d(input int i, input int v, input int n);
      dexp_t d;
      d.val = v; d.cyc = n + 2;
      dq[i].push_back(d);
   endfunction

   function automatic void compare(input string nm, input int i, input int act, input int e);
      n_cmp++;
      if (act != e) begin
         n_err++;
         $display("FAIL %s u%0d: got %0d, expected %0d (cycle %0d)", nm, i, act, e, cyc);
      end
   endfunction

   task automatic monitor(input int i);
      chk_t c;
      int act;
      forever begin
         @(negedge clk);
         while (sbq[i].size() > 0) begin
            c = sbq[i].pop_front();
            case (c.kind)
               K_DUTY: act = int'(duty_w[i]);
               K_BUSY: act = int'(busy_w[i]);
               K_PWM:  act = int'(pwm_w[i]);
               K_PCNT: act = int'(pcnt0);
               default: begin
                  act = 0;
                  for (int t = 0; t < c.len; t++) begin
                     if (t > 0) @(negedge clk);
                     act += int'(pwm_w[i]);
                  end
               end
            endcase
            compare(c.name, i, act, c.exp);
         end
      end
   endtask

   task automatic tracer(input int i);
      dexp_t d;
      logic [7:0] last = 8'd0;
      forever begin
         @(negedge clk);
         if (duty_w[i] !== last) begin
            last = duty_w[i];
            if (dq[i].size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL duty_unexpected u%0d: got %0d, expected no change (cycle %0d)",
                        i, last, cyc);
            end else begin
               d = dq[i].pop_front();
               compare("duty_value", i, int'(last), d.val);
               compare("duty_cycle", i, cyc, d.cyc);
            end
         end
      end
   endtask

   task automatic stim0();
      exp_d(0, 1, 768);
      exp_d(0, 2, 1536);
      exp_d(0, 3, 2304);
      wait_n(769);
      chk(0, "high_duty1", K_HIGH, 3, 768);
      wait_n(1537);
      chk(0, "high_duty2", K_HIGH, GAMMA ? 3 : 6, 768);
      wait_n(2400);
      chk(0, "pre_rst_duty", K_DUTY, 3);
      chk(0, "pre_rst_busy", K_BUSY, 1);
      chk(0, "pre_rst_pcnt", K_PCNT, 32);
      exp_d(0, 0, 2401);
      rst_x[0] = 1'b1;
      wait_n(2401);
      chk(0, "midrst_duty", K_DUTY, 0);
      chk(0, "midrst_pwm", K_PWM, 0);
      chk(0, "midrst_busy", K_BUSY, 0);
      chk(0, "midrst_pcnt", K_PCNT, 0);
      wait_n(2402);
      rst_x[0] = 1'b0;
      exp_d(0, 1, 3170);
      wait_n(2403);
      chk(0, "rerun_busy0", K_BUSY, 0);
      wait_n(2404);
      chk(0, "rerun_busy1", K_BUSY, 1);
      wait_n(3200);
      exp_d(0, 0, 3201);
      rst_x[0] = 1'b1;
   endtask

   task automatic stim1();
      for (int k = 1; k <= 255; k++) exp_d(1, k, 256 * k);
      wait_n(256 * 128 + 1);
      chk(1, "high_duty128", K_HIGH, GAMMA ? 64 : 128, 256);
      wait_n(65279);
      chk(1, "pre_top_duty", K_DUTY, 254);
      chk(1, "pre_top_busy", K_BUSY, 1);
      wait_n(65280);
      chk(1, "top_duty", K_DUTY, 255);
      chk(1, "top_busy", K_BUSY, 0);
      wait_n(65281);
      chk(1, "high_duty255", K_HIGH, 255, 256);
      wait_n(65540);
      chk(1, "sat_duty", K_DUTY, 255);
      chk(1, "sat_busy", K_BUSY, 0);
   endtask

   task automatic stim2();
      for (int k = 1; k <= 100; k++) exp_d(2, k, 256 * k);
      wait_n(25600);
      chk(2, "rev_duty", K_DUTY, 100);
      led_w[2] = 1'b0;
      for (int j = 1; j <= 100; j++) exp_d(2, 100 - j, 256 * (100 + j));
      wait_n(25602);
      chk(2, "rev_hold_duty", K_DUTY, 100);
      chk(2, "rev_busy", K_BUSY, 1);
      wait_n(25855);
      chk(2, "rev_hold_end", K_DUTY, 100);
      wait_n(51199);
      chk(2, "pre_off_duty", K_DUTY, 1);
      chk(2, "pre_off_busy", K_BUSY, 1);
      wait_n(51200);
      chk(2, "off_duty", K_DUTY, 0);
      chk(2, "off_busy", K_BUSY, 0);
      wait_n(51201);
      chk(2, "high_duty0", K_HIGH, 0, 256);
   endtask

   task automatic stim3();
      exp_d(3, 1, 1024);
      exp_d(3, 2, 2048);
      wait_n(1023);
      chk(3, "fade4_wait_duty", K_DUTY, 0);
      chk(3, "fade4_busy", K_BUSY, 1);
      wait_n(2100);
      chk(3, "fade4_duty2", K_DUTY, 2);
      exp_d(3, 0, 2101);
      rst_x[3] = 1'b1;
   endtask

   initial begin
      dexp_t d;
      rst_g = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rst_x[i] = 1'b0;
         led_w[i] = 1'b1;
      end
      fork
         monitor(0); monitor(1); monitor(2); monitor(3);
         tracer(0);  tracer(1);  tracer(2);  tracer(3);
      join_none
      for (int r = -1; r <= 0; r++) begin
         wait_n(r);
         for (int i = 0; i < 4; i++) begin
            chk(i, "rst_duty", K_DUTY, 0);
            chk(i, "rst_pwm", K_PWM, 0);
            chk(i, "rst_busy", K_BUSY, 0);
         end
      end
      rst_g = 1'b0;
      wait_n(1);
      for (int i = 0; i < 4; i++) begin
         chk(i, "post_rst_duty", K_DUTY, 0);
         chk(i, "post_rst_pwm", K_PWM, 0);
         chk(i, "post_rst_busy", K_BUSY, 0);
      end
      wait_n(2);
      for (int i = 0; i < 4; i++) chk(i, "busy_rise", K_BUSY, 1);
      fork
         stim0();
         stim1();
         stim2();
         stim3();
      join
      wait_n(65600);
      for (int i = 0; i < 4; i++) begin
         while (dq[i].size() > 0) begin
            d = dq[i].pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL duty_missing u%0d: got no change, expected %0d at cycle %0d",
                     i, d.val, d.cyc);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
